// File: rtl/tpu_sequencer_if.sv
// Host/DMA, activation-buffer write and TPU-system flag signals of the layer sequencer.
interface tpu_sequencer_if #(
  parameter int dataSize      = 8,
  parameter int numAddrBuffer = 8,
  parameter int tileW         = 2
);
  logic [15:0]              cfg_ifmap_width;
  logic [7:0]               cfg_num_tiles;
  logic                     cmd_start;
  logic                     cmd_busy;
  logic                     cmd_done;
  logic                     cmd_err;
  logic                     s_valid;
  logic [dataSize-1:0]      s_data;
  logic                     s_ready;
  logic                     wr_en;
  logic [numAddrBuffer-1:0] wr_addr;
  logic [dataSize-1:0]      wr_data;
  logic                     ctrl_start;
  logic                     sys_flag_done;
  logic                     sys_flag_valid;
  logic [tileW-1:0]         weight_sel;
  logic [15:0]              tile_valid_cnt;

  modport slave (
    input  cfg_ifmap_width, cfg_num_tiles, cmd_start, s_valid, s_data,
           sys_flag_done, sys_flag_valid,
    output cmd_busy, cmd_done, cmd_err, s_ready, wr_en, wr_addr, wr_data,
           ctrl_start, weight_sel, tile_valid_cnt
  );

  modport master (
    output cfg_ifmap_width, cfg_num_tiles, cmd_start, s_valid, s_data,
           sys_flag_done, sys_flag_valid,
    input  cmd_busy, cmd_done, cmd_err, s_ready, wr_en, wr_addr, wr_data,
           ctrl_start, weight_sel, tile_valid_cnt
  );
endinterface

// File: rtl/tpu_sequencer.sv
// Layer controller: loads one ifmap into the activation buffer, then runs the
// systolic system once per weight tile with a per-run watchdog.
module tpu_sequencer #(
  parameter int dataSize      = 8,
  parameter int kernelWidth   = 3,
  parameter int numRegister   = 256,
  parameter int numTiles      = 4,
  parameter int timeoutCycles = 1024
) (
  input  logic           clk,
  input  logic           nrst,
  tpu_sequencer_if.slave bus
);
  localparam int numAddrBuffer = $clog2(numRegister);
  localparam int cntW  = numAddrBuffer + 1;
  localparam int tileW = (numTiles > 1) ? $clog2(numTiles) : 1;
  localparam int wdW   = $clog2(timeoutCycles + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] RUN    = 3'd4;
  localparam logic [2:0] NEXT   = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  logic [2:0]               state;
  logic [cntW-1:0]          word_cnt, last_word;
  logic [tileW-1:0]         tile, last_tile;
  logic [15:0]              vcnt, vcnt_nx, tile_valid_cnt;
  logic [wdW-1:0]           wdog;
  logic                     cmd_err, wr_en;
  logic [numAddrBuffer-1:0] wr_addr;
  logic [dataSize-1:0]      wr_data;

  logic [31:0] wsq, tiles_m1;
  logic        cfg_bad, hs, timeout;

  always_comb begin
    wsq     = {16'd0, bus.cfg_ifmap_width} * {16'd0, bus.cfg_ifmap_width};
    cfg_bad = (bus.cfg_ifmap_width < 16'(kernelWidth)) || (wsq > 32'(numRegister));
    tiles_m1 = 32'd0;
    if (bus.cfg_num_tiles == 8'd0)
      tiles_m1 = 32'd0;
    else if (32'(bus.cfg_num_tiles) > 32'(numTiles))
      tiles_m1 = 32'(numTiles - 1);
    else
      tiles_m1 = 32'(bus.cfg_num_tiles) - 32'd1;
    hs      = (state == LOAD) && bus.s_valid;
    vcnt_nx = (bus.sys_flag_valid && vcnt != 16'hFFFF) ? vcnt + 16'd1 : vcnt;
    timeout = (wdog == wdW'(timeoutCycles - 1));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= IDLE;
      word_cnt       <= '0;
      last_word      <= '0;
      tile           <= '0;
      last_tile      <= '0;
      vcnt           <= '0;
      wdog           <= '0;
      tile_valid_cnt <= '0;
      cmd_err        <= 1'b0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
    end else begin
      cmd_err <= 1'b0;
      wr_en   <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_start) begin
          if (cfg_bad) cmd_err <= 1'b1;
          else begin
            last_word <= cntW'(wsq - 32'd1);
            last_tile <= tileW'(tiles_m1);
            word_cnt  <= '0;
            tile      <= '0;
            state     <= LOAD;
          end
        end
        LOAD: if (hs) begin
          wr_en    <= 1'b1;
          wr_addr  <= word_cnt[numAddrBuffer-1:0];
          wr_data  <= bus.s_data;
          word_cnt <= word_cnt + 1'b1;
          if (word_cnt == last_word) state <= SETTLE;
        end
        SETTLE: state <= START;
        START: begin
          vcnt  <= '0;
          wdog  <= '0;
          state <= RUN;
        end
        RUN: begin
          vcnt <= vcnt_nx;
          wdog <= wdog + 1'b1;
          // done has priority over a watchdog expiring in the same cycle
          if (bus.sys_flag_done) begin
            tile_valid_cnt <= vcnt_nx;
            state          <= NEXT;
          end else if (timeout) begin
            cmd_err <= 1'b1;
            state   <= IDLE;
          end
        end
        NEXT: begin
          if (tile == last_tile) state <= DONE;
          else begin
            tile  <= tile + 1'b1;
            state <= SETTLE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_busy       = (state != IDLE);
  assign bus.cmd_done       = (state == DONE);
  assign bus.cmd_err        = cmd_err;
  assign bus.s_ready        = (state == LOAD);
  assign bus.wr_en          = wr_en;
  assign bus.wr_addr        = wr_addr;
  assign bus.wr_data        = wr_data;
  assign bus.ctrl_start     = (state == START);
  assign bus.weight_sel     = tile;
  assign bus.tile_valid_cnt = tile_valid_cnt;
endmodule
